// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage with one outstanding SRAM-like fetch
// Discards wrong-path responses after an exception/ertn or branch redirect.
module if_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        from_valid,
  input  logic [31:0] nextpc,
  output logic        to_allowin,
  input  logic        ex_en,
  input  logic        br_taken,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] fs_inst_q, fs_inst_d;
  logic        flush;

  assign flush      = ex_en | br_taken;
  assign to_allowin = flush | (state_q == S_IDLE) | ((state_q == S_HOLD) & ds_allowin);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fs_pc_d   = fs_pc_q;
    fs_inst_d = fs_inst_q;
    if (flush) begin
      // The redirect PC is captured now; the request waits until any in-flight response drains.
      pc_d = nextpc;
      unique case (state_q)
        S_IDLE, S_HOLD: state_d = S_REQ;
        S_REQ:          state_d = inst_sram_addr_ok ? S_DROP : S_REQ;
        S_WAIT:         state_d = inst_sram_data_ok ? S_REQ : S_DROP;
        S_DROP:         state_d = inst_sram_data_ok ? S_REQ : S_DROP;
        default:        state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (from_valid) begin
            state_d = S_REQ;
            pc_d    = nextpc;
          end
        end
        S_REQ: begin
          if (inst_sram_addr_ok) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            state_d   = S_HOLD;
            fs_inst_d = inst_sram_rdata;
            fs_pc_d   = pc_q;
          end
        end
        S_HOLD: begin
          if (ds_allowin) begin
            if (from_valid) begin
              state_d = S_REQ;
              pc_d    = nextpc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (inst_sram_data_ok) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      fs_pc_q   <= 32'd0;
      fs_inst_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fs_pc_q   <= fs_pc_d;
      fs_inst_q <= fs_inst_d;
    end
  end

  assign inst_sram_req   = (state_q == S_REQ);
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'd0;
  assign fs_valid        = (state_q == S_HOLD);
  assign fs_pc           = fs_pc_q;
  assign fs_inst         = fs_inst_q;

endmodule
